// File: rtl/uart_instruction_loader.sv
// uart_instruction_loader: receives an 8N1 UART program image (LE word count, then LE words)
// and writes it word by word into instruction memory, flagging done or error stickily.
module uart_instruction_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] byte_address,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        load_done,
  output logic        load_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {LEN, DATA, WRITE, DONE, ERROR} ld_t;
  logic [1:0] sync_q;
  rx_t rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic bv_q, bv_d, fe_q, fe_d;
  ld_t st_q, st_d;
  logic [31:0] n_q, n_d, idx_q, idx_d, word_q, word_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [31:0] n_sh, w_sh;
  logic rx_s;
  assign rx_s = sync_q[1];
  always_comb begin
    rx_d  = rx_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    bv_d  = 1'b0;
    fe_d  = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) rx_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        rx_d  = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_d = RX_STOP;
      end
      default: if (cnt_q == LAST) begin
        rx_d = RX_IDLE;
        bv_d = rx_s;
        fe_d = !rx_s;
      end
    endcase
  end
  // Length and data bytes shift in from the top so byte 0 lands in bits [7:0].
  assign n_sh = {sh_q, n_q[31:8]};
  assign w_sh = {sh_q, word_q[31:8]};
  always_comb begin
    st_d    = st_q;
    n_d     = n_q;
    idx_d   = idx_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (st_q)
      LEN: if (bv_q) begin
        n_d    = n_sh;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) st_d = n_sh == 32'd0 ? DONE : n_sh > 32'(MAX_WORDS) ? ERROR : DATA;
      end
      DATA: if (bv_q) begin
        word_d = w_sh;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          st_d    = WRITE;
          addr_d  = {idx_q[29:0], 2'b00};
          wdata_d = w_sh;
        end
      end
      WRITE: begin
        idx_d = idx_q + 32'd1;
        st_d  = idx_q + 32'd1 == n_q ? DONE : DATA;
      end
      default: ;
    endcase
    if (fe_q && (st_q == LEN || st_q == DATA || st_q == WRITE)) st_d = ERROR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      rx_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
      st_q    <= LEN;
      n_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
      st_q    <= st_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign byte_address = addr_q;
  assign write_data   = wdata_q;
  assign write_enable = st_q == WRITE;
  assign busy         = st_q == DATA || st_q == WRITE || (st_q == LEN && bcnt_q != 2'd0);
  assign load_done    = st_q == DONE;
  assign load_error   = st_q == ERROR;
endmodule

// File: tb/tb_uart_instruction_loader.sv
// tb_uart_instruction_loader: directed UART program loads checked against a byte-stream model
// of the load protocol (expected write list, final done/error) on every cycle.
module tb_uart_instruction_loader;
  localparam int CPB = 4;
  localparam int MAXW = 16;
  logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic [31:0] byte_address, write_data;
  logic write_enable, busy, load_done, load_error;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  logic [7:0] stim[$];
  int tests = 0, fails = 0, exp_nw = 0;
  logic exp_done, exp_err, we_prev = 1'b0, done_prev = 1'b0;
  uart_instruction_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .byte_address(byte_address),
    .write_enable(write_enable), .write_data(write_data), .busy(busy),
    .load_done(load_done), .load_error(load_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  // Protocol model: whole byte stream plus index of a byte whose stop bit is bad (-1: none).
  task automatic model(input int f);
    logic [31:0] n;
    int base;
    exp_q.delete();
    exp_nw = 0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    if (stim.size() < 4 || (f >= 0 && f < 4)) begin
      exp_err = f >= 0 && f < 4;
      return;
    end
    n = {stim[3], stim[2], stim[1], stim[0]};
    if (n > MAXW) exp_err = 1'b1;
    else if (n == 0) exp_done = 1'b1;
    else begin
      for (int k = 0; k < int'(n); k++) begin
        base = 4 + 4 * k;
        if (base + 3 >= stim.size() || (f >= 0 && f <= base + 3)) break;
        exp_q.push_back('{a: 32'(4 * k), d: {stim[base+3], stim[base+2], stim[base+1], stim[base]}});
        exp_nw++;
      end
      if (exp_nw == int'(n)) exp_done = 1'b1;
      else if (f >= 0) exp_err = 1'b1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask
  task automatic send_all(input int f);
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], i != f);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, write_enable}, 0);
    chk("rst_addr", byte_address, 0);
    chk("rst_data", write_data, 0);
    chk("rst_flags", {29'd0, busy, load_done, load_error}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic finish_check(input string nm);
    repeat (20) @(negedge clk);
    chk({nm, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
    chk({nm, "_err"}, {31'd0, load_error}, {31'd0, exp_err});
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (write_enable) begin
        if (exp_q.size() == 0) chk("unexpected_write", byte_address, 32'hFFFF_FFFF);
        else begin
          chk("wr_addr", byte_address, exp_q[0].a);
          chk("wr_data", write_data, exp_q[0].d);
          void'(exp_q.pop_front());
        end
      end
      if (load_done || load_error) chk("idle_outputs", {30'd0, busy, write_enable}, 0);
      if (load_done && !done_prev) chk("done_after_last_write", {31'd0, exp_nw == 0 || we_prev}, 1);
    end
    we_prev <= write_enable;
    done_prev <= load_done;
  end
  initial begin
    do_reset();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    model(-1);
    chk("model_nom_cnt", exp_q.size(), 2);
    chk("model_nom_w1", exp_q[1].d, 32'h00100113);
    chk("model_nom_a1", exp_q[1].a, 32'h4);
    send_byte(stim[0], 1'b1);
    chk("busy_after_len_byte", {31'd0, busy}, 1);
    for (int i = 1; i < stim.size(); i++) send_byte(stim[i], 1'b1);
    finish_check("nominal");
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    model(-1);
    send_all(-1);
    finish_check("zero_len");
    do_reset();
    stim = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    model(-1);
    chk("model_over_err", {31'd0, exp_err}, 1);
    send_all(-1);
    finish_check("oversize");
    do_reset();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    model(6);
    send_all(6);
    finish_check("framing");
    do_reset();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_no_byte", {31'd0, busy}, 0);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model(-1);
    chk("model_glitch_w0", exp_q[0].d, 32'hDEADBEEF);
    send_all(-1);
    finish_check("glitch");
    do_reset();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    model(-1);
    send_all(-1);
    chk("mid_word_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {29'd0, busy, load_done, load_error}, 0);
    chk("async_rst_we", {31'd0, write_enable}, 0);
    chk("async_rst_pending", exp_q.size(), 0);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    model(-1);
    chk("model_fresh_w0", exp_q[0].d, 32'h00000013);
    send_all(-1);
    finish_check("after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
